// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// signed and unsigned, with architectural HI/LO and MTHI/MTLO writes.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_hold;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;

    logic               accept;
    logic               signed_op;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign accept    = !busy && start;
    assign signed_op = !op[0];
    assign sgn_a     = signed_op && a[WIDTH-1];
    assign sgn_b     = signed_op && b[WIDTH-1];

    // Multiply adds into the upper half with a carry bit; divide trial-subtracts
    // from the shifted remainder, which needs one extra bit above WIDTH.
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
    assign trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};

    always_comb begin
        acc_nxt = acc;
        if (op_hold[1]) begin
            if (!trial[WIDTH]) begin
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // A zero divisor leaves the remainder equal to |a|, so sign correction restores a.
    assign prod = neg_2w(acc, neg_q);
    assign quo  = b_zero ? '1 : neg_w(acc[WIDTH-1:0], neg_q);
    assign rem  = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_hold <= op;
            mag_b   <= sgn_b ? -b : b;
            acc     <= {{WIDTH{1'b0}}, (sgn_a ? -a : a)};
            neg_q   <= sgn_a ^ sgn_b;
            neg_r   <= sgn_a;
            b_zero  <= (b == '0);
            cnt     <= '0;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= 1'b0;
            if (!busy) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (accept) div_zero <= 1'b0;
            if (state == FIN) begin
                done <= 1'b1;
                if (op_hold[1]) begin
                    hi       <= rem;
                    lo       <= quo;
                    div_zero <= b_zero;
                end else begin
                    {hi, lo} <= prod;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/div_zero and completion cycle
// are queued at each accepted start and checked when done pulses.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dz = 1'b0;
        r.due = 0;
        r.hi = '0;
        r.lo = '0;
        case (o)
            2'd0: begin
                p = sx * sy;
                {r.hi, r.lo} = p;
            end
            2'd1: begin
                p = {32'b0, x} * {32'b0, y};
                {r.hi, r.lo} = p;
            end
            2'd2: begin
                if (y == '0) begin
                    r.hi = x; r.lo = '1; r.dz = 1'b1;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r.lo = sq[31:0];
                    r.hi = sr[31:0];
                end
            end
            default: begin
                if (y == '0) begin
                    r.hi = x; r.lo = '1; r.dz = 1'b1;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    // Called just after a clock edge; returns just after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) check_val("wait_idle", busy, 0);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(o, x, y);
        e.due = cyc + W + 1;
        sb.push_back(e);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((busy || sb.size() != 0) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) check_val("drain_timeout", sb.size(), 0);
    endtask

    logic prev_done = 1'b0;
    exp_t got_e;
    always @(posedge clk) begin
        #1;
        if (prev_done) check_val("done_width", done, 0);
        if (done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", done, 0);
            end else begin
                got_e = sb.pop_front();
                check_val("res_hi", hi, got_e.hi);
                check_val("res_lo", lo, got_e.lo);
                check_val("res_div_zero", div_zero, got_e.dz);
                check_val("res_latency", cyc, got_e.due);
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;

        // Full-latency timing of one MULTU, hi/lo held during the computation.
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k <= W; k++) begin
            check_val("busy_hold", busy, 1);
            check_val("done_early", done, 0);
            check_val("hi_stable", hi, 0);
            @(posedge clk); #1;
        end
        check_val("busy_end", busy, 0);
        check_val("done_pulse", done, 1);
        @(posedge clk); #1;
        check_val("done_low", done, 0);

        // Signed multiply, then back-to-back start in the done cycle.
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000);

        // Divides including signed overflow wrap.
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'd7, 32'd2);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE);

        // Divide by zero: flag holds until the next accepted start.
        run_op(2'd3, 32'd7, 32'd0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_val("dz_hold", div_zero, 1);
        run_op(2'd3, 32'd9, 32'd3);
        check_val("dz_clear", div_zero, 0);
        drain();

        // start and MT writes while busy are ignored.
        run_op(2'd1, 32'h1234_5678, 32'h0000_0100);
        repeat (5) @(posedge clk);
        #1;
        op = 2'd2; a = 32'd100; b = 32'd3; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check_val("mt_busy_hi", hi, 32'd0);
        check_val("mt_busy_lo", lo, 32'd3);
        drain();

        // MTLO when idle.
        lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check_val("mtlo_lo", lo, 32'h1234);
        check_val("mtlo_hi", hi, 32'h12);

        // Both MT enables together.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check_val("mtboth_hi", hi, 32'hA5A5_0F0F);
        check_val("mtboth_lo", lo, 32'hA5A5_0F0F);

        // Reset in the middle of a multiply discards it.
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_hi", hi, 0);
        check_val("midrst_lo", lo, 0);
        run_op(2'd0, 32'hFFFF_FFF0, 32'd7);
        drain();

        // Mixed random operations issued back-to-back.
        for (int i = 0; i < 12; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(ro, ra, rb);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
